// File: rtl/ann_out_streamer_if.sv
// Handshake bundle of the ANN result streamer: result-vector offer from the
// core plus the byte/valid/ack link to the external host.
interface ann_out_streamer_if #(
  parameter int N_NEURONS = 4
);
  logic                   res_valid;
  logic [8*N_NEURONS-1:0] res_data;
  logic                   res_ready;
  logic                   host_ack;
  logic [7:0]             out_data;
  logic                   out_valid;

  modport master (
    input  res_valid, res_data, host_ack,
    output res_ready, out_data, out_valid
  );

  modport slave (
    output res_valid, res_data, host_ack,
    input  res_ready, out_data, out_valid
  );
endinterface

// File: rtl/ann_out_streamer.sv
// Sends one captured result vector to the host as HDR, data bytes, XOR checksum,
// each byte paced by a 4-phase valid/ack handshake on a synchronised host_ack.
module ann_out_streamer #(
  parameter int         N_NEURONS = 4,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  ann_out_streamer_if.master  bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = $clog2(N_NEURONS + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS + 1);
  localparam logic [IDX_W-1:0] CSUM_PRE = IDX_W'(N_NEURONS);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_e;

  state_e                 r_state;
  state_e                 w_nextState;
  logic                   r_ackMeta;
  logic                   r_ackSync;
  logic [8*N_NEURONS-1:0] r_shadow;
  logic [IDX_W-1:0]       r_index;
  logic [7:0]             r_csum;
  logic [7:0]             r_outData;
  logic                   r_outValid;
  logic                   r_frameDone;

  logic                   w_accept;
  logic                   w_ackSeen;
  logic                   w_loadNext;
  logic                   w_finish;
  logic [7:0]             w_dataByte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.res_valid) w_nextState = WAIT_HI;
      WAIT_HI: if (r_ackSync)     w_nextState = WAIT_LO;
      WAIT_LO: if (!r_ackSync)    w_nextState = (r_index == LAST_IDX) ? IDLE : WAIT_HI;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_accept   = (r_state == IDLE) && bus.res_valid;
    w_ackSeen  = (r_state == WAIT_HI) && r_ackSync;
    w_loadNext = (r_state == WAIT_LO) && !r_ackSync && (r_index != LAST_IDX);
    w_finish   = (r_state == WAIT_LO) && !r_ackSync && (r_index == LAST_IDX);
  end

  // Index k (1..N) carries data byte k-1, so the byte loaded next is r_index.
  always_comb begin
    w_dataByte = 8'h00;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (r_index == IDX_W'(k)) w_dataByte = r_shadow[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ackMeta   <= 1'b0;
      r_ackSync   <= 1'b0;
      r_shadow    <= '0;
      r_index     <= '0;
      r_csum      <= 8'h00;
      r_outData   <= 8'h00;
      r_outValid  <= 1'b0;
      r_frameDone <= 1'b0;
    end else if (ena) begin
      r_ackMeta   <= bus.host_ack;
      r_ackSync   <= r_ackMeta;
      r_frameDone <= w_finish;
      if (w_accept) begin
        r_shadow   <= bus.res_data;
        r_index    <= '0;
        r_csum     <= 8'h00;
        r_outData  <= HDR_BYTE;
        r_outValid <= 1'b1;
      end else if (w_ackSeen) begin
        r_outValid <= 1'b0;
      end else if (w_loadNext) begin
        r_index    <= r_index + IDX_W'(1);
        r_outValid <= 1'b1;
        if (r_index == CSUM_PRE) begin
          r_outData <= r_csum;
        end else begin
          r_outData <= w_dataByte;
          r_csum    <= r_csum ^ w_dataByte;
        end
      end
    end else begin
      r_frameDone <= 1'b0;
    end
  end

  assign bus.res_ready = (r_state == IDLE);
  assign bus.out_data  = r_outData;
  assign bus.out_valid = r_outValid;
  assign busy          = (r_state != IDLE);
  assign frame_done    = r_frameDone & ena;

endmodule

// File: tb/tb_ann_out_streamer.sv
// Self-checking bench for ann_out_streamer: a host model acknowledges each byte
// and the received stream is compared with frames built from the framing rules.
module tb_ann_out_streamer;

  localparam int         N         = 4;
  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         FRAME_LEN = N + 2;
  localparam int         TIMEOUT   = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  logic busy;
  logic frame_done;

  ann_out_streamer_if #(.N_NEURONS(N)) bus ();

  ann_out_streamer #(.N_NEURONS(N), .HDR_BYTE(HDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int doneCount = 0;

  logic [7:0] expFrame[$];
  logic [7:0] rxBytes[$];
  int         rxUnstable;
  bit         rxTimeout;
  bit         sendTimeout;
  logic       acceptValid;
  logic [7:0] acceptData;

  always @(negedge clk) if (frame_done === 1'b1) doneCount++;

  // Reference frame: header, data bytes low to high, XOR of data bytes only.
  function automatic void build_frame(input logic [8*N-1:0] v);
    logic [7:0] cs;
    expFrame.delete();
    expFrame.push_back(HDR);
    cs = 8'h00;
    for (int k = 0; k < N; k++) begin
      expFrame.push_back(v[8*k +: 8]);
      cs = cs ^ v[8*k +: 8];
    end
    expFrame.push_back(cs);
  endfunction

  task automatic send_vector(input logic [8*N-1:0] v);
    @(negedge clk);
    bus.res_data  = v;
    bus.res_valid = 1'b1;
    sendTimeout   = 1'b1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        sendTimeout = 1'b0;
        break;
      end
    end
    acceptValid   = bus.out_valid;
    acceptData    = bus.out_data;
    bus.res_valid = 1'b0;
  endtask

  // Host side: capture each valid byte, ack after ackDelay cycles, release after valid drops.
  task automatic host_receive(input int nBytes, input int ackDelay);
    logic [7:0] cur;
    bit seen;
    rxBytes.delete();
    rxUnstable = 0;
    rxTimeout  = 1'b0;
    for (int b = 0; b < nBytes; b++) begin
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
        if (bus.out_valid === 1'b1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        rxTimeout = 1'b1;
        return;
      end
      cur = bus.out_data;
      rxBytes.push_back(cur);
      repeat (ackDelay) begin
        @(negedge clk);
        if (bus.out_data !== cur || bus.out_valid !== 1'b1) rxUnstable++;
      end
      bus.host_ack = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
        @(negedge clk);
        if (bus.out_data !== cur) rxUnstable++;
        if (bus.out_valid === 1'b0) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        rxTimeout = 1'b1;
        bus.host_ack = 1'b0;
        return;
      end
      bus.host_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.host_ack  = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (bus.res_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
          busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: got ready=%b valid=%b data=%h busy=%b done=%b, want 1 0 00 0 0",
                 c, bus.res_ready, bus.out_valid, bus.out_data, busy, frame_done);
      end
    end
  endtask

  task automatic test_single_frame();
    int d0;
    build_frame(32'h04030201);
    d0 = doneCount;
    send_vector(32'h04030201);
    total++;
    if (sendTimeout || acceptValid !== 1'b1 || acceptData !== HDR) begin
      bad++;
      $display("[TB] FAIL single_accept: got timeout=%b valid=%b data=%h, want 0 1 %h",
               sendTimeout, acceptValid, acceptData, HDR);
    end
    host_receive(FRAME_LEN, 2);
    total++;
    if (rxTimeout || rxBytes.size() != FRAME_LEN) begin
      bad++;
      $display("[TB] FAIL single_count: got %0d bytes timeout=%b, want %0d", rxBytes.size(), rxTimeout, FRAME_LEN);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL single_byte%0d: got %h, want %h", i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
      end
    end
    total++;
    if (rxUnstable != 0) begin
      bad++;
      $display("[TB] FAIL single_stable: got %0d unstable samples, want 0", rxUnstable);
    end
    total++;
    if (doneCount != d0) begin
      bad++;
      $display("[TB] FAIL single_early_done: got %0d pulses before ack fell, want 0", doneCount - d0);
    end
    repeat (10) @(negedge clk);
    total++;
    if (doneCount - d0 != 1 || bus.res_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_done: got pulses=%0d ready=%b busy=%b, want 1 1 0", doneCount - d0, bus.res_ready, busy);
    end
  endtask

  task automatic test_checksum();
    build_frame(32'hFF00AA55);
    send_vector(32'hFF00AA55);
    host_receive(FRAME_LEN, 1);
    total++;
    if (rxTimeout || rxBytes.size() != FRAME_LEN || rxUnstable != 0) begin
      bad++;
      $display("[TB] FAIL csum_count: got %0d bytes timeout=%b unstable=%0d, want %0d 0 0",
               rxBytes.size(), rxTimeout, rxUnstable, FRAME_LEN);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL csum_byte%0d: got %h, want %h", i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_busy_reject();
    logic [7:0] got[$];
    bit seen;
    build_frame(32'h04030201);
    send_vector(32'h04030201);
    host_receive(1, 2);
    got = rxBytes;
    bus.res_data  = 32'hDEADBEEF;
    bus.res_valid = 1'b1;
    host_receive(FRAME_LEN - 1, 2);
    foreach (rxBytes[i]) got.push_back(rxBytes[i]);
    total++;
    if (rxTimeout || got.size() != FRAME_LEN) begin
      bad++;
      $display("[TB] FAIL reject_count: got %0d bytes timeout=%b, want %0d", got.size(), rxTimeout, FRAME_LEN);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= got.size() || got[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL reject_frame1_byte%0d: got %h, want %h", i, (i < got.size()) ? got[i] : 8'hxx, expFrame[i]);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reject_done_cycle: got done_seen=%b busy=%b, want 1 0", seen, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.out_data !== HDR) begin
      bad++;
      $display("[TB] FAIL reject_accept_next: got busy=%b data=%h, want 1 %h", busy, bus.out_data, HDR);
    end
    bus.res_valid = 1'b0;
    build_frame(32'hDEADBEEF);
    host_receive(FRAME_LEN, 2);
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (rxTimeout || i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL reject_frame2_byte%0d: got %h, want %h", i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ena_gating();
    logic [31:0] v;
    logic       holdValid;
    logic [7:0] holdData;
    int d0;
    v = $urandom;
    build_frame(v);
    send_vector(v);
    d0 = doneCount;
    holdValid = bus.out_valid;
    holdData  = bus.out_data;
    ena = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.host_ack = (c % 2 == 0);
      @(negedge clk);
      total++;
      if (bus.out_valid !== holdValid || bus.out_data !== holdData || frame_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ena_frozen cycle %0d: got valid=%b data=%h done=%b, want %b %h 0",
                 c, bus.out_valid, bus.out_data, frame_done, holdValid, holdData);
      end
    end
    bus.host_ack = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    host_receive(FRAME_LEN, 2);
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (rxTimeout || i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL ena_resume_byte%0d: got %h, want %h", i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (doneCount - d0 != 1) begin
      bad++;
      $display("[TB] FAIL ena_done: got %0d pulses, want 1", doneCount - d0);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    bit seen;
    v = $urandom;
    build_frame(v);
    send_vector(v);
    host_receive(3, 1);
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (rxTimeout || !seen || bus.out_data !== expFrame[3]) begin
      bad++;
      $display("[TB] FAIL areset_byte3: got seen=%b data=%h, want 1 %h", seen, bus.out_data, expFrame[3]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.res_ready !== 1'b1 || bus.out_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL areset_immediate: got valid=%b busy=%b ready=%b data=%h, want 0 0 1 00",
               bus.out_valid, busy, bus.res_ready, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = $urandom;
    build_frame(v);
    send_vector(v);
    host_receive(FRAME_LEN, 1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (rxTimeout || i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
        bad++;
        $display("[TB] FAIL areset_next_byte%0d: got %h, want %h", i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic [31:0] v;
    int d0;
    for (int f = 0; f < 5; f++) begin
      v = $urandom;
      build_frame(v);
      d0 = doneCount;
      send_vector(v);
      host_receive(FRAME_LEN, $urandom_range(0, 4));
      for (int i = 0; i < FRAME_LEN; i++) begin
        total++;
        if (rxTimeout || i >= rxBytes.size() || rxBytes[i] !== expFrame[i]) begin
          bad++;
          $display("[TB] FAIL random%0d_byte%0d: got %h, want %h", f, i, (i < rxBytes.size()) ? rxBytes[i] : 8'hxx, expFrame[i]);
        end
      end
      repeat (8) @(negedge clk);
      total++;
      if (doneCount - d0 != 1 || rxUnstable != 0) begin
        bad++;
        $display("[TB] FAIL random%0d_done: got pulses=%0d unstable=%0d, want 1 0", f, doneCount - d0, rxUnstable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_checksum();
    test_busy_reject();
    test_ena_gating();
    test_async_reset();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ann_out_streamer.md
Name: ann_out_streamer

Overview:
- Transmit side of the chip's host byte interface: takes one result vector of N_NEURONS 8-bit neuron outputs from the ANN core and sends it to the external host as a framed byte stream on uo_out.
- Each byte is paced by a 4-phase valid/ack handshake: out_valid goes out on uio_out[0], host_ack comes in on uio_in[1].
- Counterpart of the host-to-chip byte loader that drives ui_in.

Parameters:
- N_NEURONS, 4, number of result bytes per frame (1..16)
- HDR_BYTE, 8'hA5, frame header byte

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  clock-enable; when 0 all state holds
- res_valid  input  1  core offers a result vector
- res_data  input  8*N_NEURONS  result vector; neuron k in bits [8k+7:8k]
- res_ready  output  1  streamer can accept a vector
- host_ack  input  1  asynchronous host acknowledge
- out_data  output  8  byte to host (to uo_out)
- out_valid  output  1  byte valid strobe (to uio_out[0])
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when the last byte is acknowledged

Behaviour:
- Clock and reset:
  - Single clock domain. Async reset clears everything.
  - Reset values: res_ready=1, out_data=0, out_valid=0, busy=0, frame_done=0, state=IDLE, byte index=0, checksum=0, sync flops=0.
  - Reset mid-frame aborts the frame; no partial recovery.
- host_ack synchronisation: 2-flop synchroniser produces ack_s. All handshake decisions use ack_s only.
- ena=0: state, index, registers and outputs hold. frame_done is forced 0 while ena=0.
- Frame format: HDR_BYTE, then res_data bytes 0..N_NEURONS-1, then CSUM. CSUM is the XOR of the data bytes only; the header is excluded. Frame length is N_NEURONS+2 bytes.
- States: IDLE, WAIT_HI, WAIT_LO.
  - IDLE: res_ready=1, busy=0. On res_valid=1, capture res_data into a shadow register, clear the checksum, set index=0, then go to WAIT_HI. Entering WAIT_HI sets out_data=HDR_BYTE and out_valid=1 on that same edge, so latency from the accept edge to first valid is 0 cycles. res_ready=0 whenever the state is not IDLE.
  - WAIT_HI: out_valid=1, out_data stable. When ack_s=1, clear out_valid on the next edge and go to WAIT_LO.
  - WAIT_LO: out_valid=0, out_data still held. When ack_s=0:
    - If the current byte is the last (CSUM), go to IDLE, pulse frame_done for one cycle, and set res_ready=1 on that same edge.
    - Otherwise, increment index, load the next byte, set out_valid=1 and return to WAIT_HI, all on the same edge.
    - The checksum accumulates each data byte as it is loaded.
- Boundaries:
  - ack_s already high on entry to WAIT_HI (host left ack asserted): treated as an acknowledge. The host protocol forbids this; the bench checks only that no byte is skipped without an ack_s rising/falling pair seen by the FSM.
  - ack_s stuck high in WAIT_LO: wait indefinitely, no timeout.
  - res_valid while busy: ignored. The core must hold res_valid until it sees res_ready.
  - res_valid asserted in the same cycle frame_done pulses: not accepted; accepted on the next cycle (IDLE).
  - Index width is clog2(N_NEURONS+2). The index never wraps within a frame.
- Throughput: each byte takes at least 6 cycles with an immediate host (2 sync + 2 sync + transition edges).

Test Plan:
- Reset then idle: rst_n low, then high, no stimulus -> res_ready=1, out_valid=0, out_data=0, busy=0 for 20 cycles.
- Single frame, N_NEURONS=4, res_data=32'h04030201, host acks 2 cycles after each valid edge -> bytes A5,01,02,03,04,04 in order, each held stable while out_valid=1; exactly one frame_done pulse after the 6th ack falls; res_ready returns to 1.
- Checksum: res_data=32'hFF00AA55 -> bytes A5,55,AA,00,FF, CSUM 00.
- Busy rejection: assert res_valid with 32'hDEADBEEF during frame 1 -> ignored. A held res_valid is accepted on the cycle after frame_done -> second frame A5,EF,BE,AD,DE,CSUM 22.
- ena gating: drop ena for 10 cycles while in WAIT_HI and toggle host_ack during the gap -> out_data and out_valid frozen, no frame_done. After ena returns, the sequence resumes with no skipped or duplicated byte.
- Async reset mid-frame: assert rst_n low during byte 3 (asynchronous to clk) -> out_valid=0 and busy=0 immediately; a following frame starts cleanly with HDR_BYTE.
